countdown_timer_ml: RTL
=======================

// Module: countdown_timer_ml
// PURPOSE
//  Multi-level ms countdown timer for the game datapath; successor to the single-mode timer.
//  Adds a parametrised start table, a start/pause/clear FSM, saturating bonus-time add,
//  a one-cycle expiry pulse and a sticky time-up flag. Drives the score/display logic.
// PARAMETERS
//  MAX_MS       2047                   max count; CNT_W = $clog2(MAX_MS+1)
//  CLKS_PER_MS  50000                  clk cycles per ms tick (50 MHz)
//  N_LEVELS     4                      number of selectable levels; LEVEL_W = $clog2(N_LEVELS)
//  START_TABLE  {250,500,1000,1000}    N_LEVELS*CNT_W packed start values, level 0 in LSBs
//  BONUS_W      8                      width of bonus_ms
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        async active-low reset
//  level        in   LEVEL_W  level select, sampled in IDLE and on start
//  start        in   1        pulse: load START_TABLE[level] and run (restarts if running)
//  pause        in   1        level: hold count and prescaler while high
//  clear        in   1        pulse: abort to IDLE
//  bonus_valid  in   1        pulse: add bonus_ms to count (RUN/PAUSED only)
//  bonus_ms     in   BONUS_W  bonus amount in ms
//  timer_value  out  CNT_W    remaining ms
//  running      out  1        high in RUN
//  expired      out  1        one-cycle pulse when count reaches 0
//  time_up      out  1        high in EXPIRED
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, timer_value=0, prescaler=0, outputs 0.
//  States: IDLE, RUN, PAUSED, EXPIRED. Input priority per cycle: clear > start > bonus > tick.
//  IDLE: timer_value <= START_TABLE[level] every cycle. start -> RUN.
//  RUN: prescaler counts 0..CLKS_PER_MS-1, wraps; at CLKS_PER_MS-1 count decrements.
//   pause=1 -> PAUSED (prescaler frozen, not cleared). Reaching 0 -> EXPIRED.
//  PAUSED: count and prescaler held; pause=0 -> RUN, resumes mid-ms exactly.
//  EXPIRED: timer_value=0, time_up=1; only start or clear leave; bonus ignored.
//  start (any state, no clear): prescaler <= 0, count <= START_TABLE[level], next state RUN.
//   Latency: start at cycle t -> value visible at t+1, first decrement at t+1+CLKS_PER_MS.
//  clear (any state): next state IDLE, prescaler <= 0, expired not asserted.
//  Bonus and tick in the same cycle: count <= sat(count - 1 + bonus_ms, MAX_MS) in CNT_W+1 bits.
//   If the result is >0, no expiry; if the result is 0, expire.
//  Bonus alone: count <= min(count + bonus_ms, MAX_MS).
//  expired is registered with the 1->0 count transition, so both are visible in the same cycle.
//  level >= N_LEVELS (non-power-of-2 N_LEVELS) selects level 0.
//  Elaboration: $error if any START_TABLE entry > MAX_MS or is 0.
//  level and pause changes have no effect in EXPIRED. pause is ignored in IDLE.
// STRUCTURE
//  timer_pkg: state enum, CNT_W/LEVEL_W helper functions, default START_TABLE constant.
//  Sub-module ms_tick_gen (param CLKS_PER_MS; inputs en, sync_clr; output one-cycle tick).
//  Top: FSM, start-value mux, saturating add/decrement, output regs.
// TESTING  (CLKS_PER_MS=4, MAX_MS=15, START_TABLE={3,5,8,10})
//  1 level=0, start -> timer_value 10 at t+1, 9 at t+5; expired pulses once when value hits 0
//    at t+41, then time_up=1 and running=0.
//  2 level=2, start, pause high for 7 cycles after 2 prescaler counts -> count frozen at 5;
//    decrement lands 2 cycles after pause drops.
//  3 count=14, bonus_ms=5 -> 15 (saturated). Count=1 with bonus=3 on the tick cycle -> 3,
//    no expired pulse.
//  4 clear in RUN at count 6 -> IDLE next cycle, value = table[level], no expired pulse.
//    start while clear is asserted -> stays IDLE.
//  5 start in EXPIRED and mid-RUN -> reload to table value, prescaler restarts from 0.
//  6 rst_n low mid-RUN (async, off clock edge) -> outputs 0 immediately. After release,
//    IDLE loads the table value on the next edge.

Source files
------------

// File: rtl/countdown_timer_ml_pkg.sv
// countdown_timer_ml_pkg: shared state encoding, width helpers and default start table
package countdown_timer_ml_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED} state_e;

  function automatic int cnt_w(input int max_ms);
    return $clog2(max_ms + 1);
  endfunction

  function automatic int level_w(input int n_levels);
    return (n_levels > 1) ? $clog2(n_levels) : 1;
  endfunction

  localparam logic [4*11-1:0] DEF_START_TABLE = {11'd250, 11'd500, 11'd1000, 11'd1000};

endpackage

// File: rtl/countdown_timer_ml_tick.sv
// ms_tick_gen: free-running prescaler producing a one-cycle tick every CLKS_PER_MS enabled cycles
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);
  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en & (cnt_q == LAST);

  // Count only while enabled so a pause resumes mid-ms; clear restarts the ms
  always_comb cnt_d = sync_clr ? '0 : (en ? (tick ? '0 : cnt_q + 1'b1) : cnt_q);

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;

endmodule

// File: rtl/countdown_timer_ml.sv
// countdown_timer_ml: multi-level ms countdown with pause, clear, saturating bonus and expiry flags
module countdown_timer_ml
  import countdown_timer_ml_pkg::*;
#(
  parameter int MAX_MS      = 2047,
  parameter int CLKS_PER_MS = 50000,
  parameter int N_LEVELS    = 4,
  parameter logic [N_LEVELS*cnt_w(MAX_MS)-1:0] START_TABLE = DEF_START_TABLE,
  parameter int BONUS_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [level_w(N_LEVELS)-1:0]   level,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           clear,
  input  logic                           bonus_valid,
  input  logic [BONUS_W-1:0]             bonus_ms,
  output logic [cnt_w(MAX_MS)-1:0]       timer_value,
  output logic                           running,
  output logic                           expired,
  output logic                           time_up
);
  localparam int CNT_W   = cnt_w(MAX_MS);
  localparam int LEVEL_W = level_w(N_LEVELS);
  localparam int SW      = ((CNT_W > BONUS_W) ? CNT_W : BONUS_W) + 1;
  localparam logic [SW-1:0] MAX_SW = SW'(MAX_MS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              expired_q, expired_d;
  logic [CNT_W-1:0]  lut [2**LEVEL_W];
  logic [CNT_W-1:0]  start_val, sat_cnt;
  logic [SW-1:0]     sum;
  logic              active, sync_clr, en, tick, bonus_hit;

  // Unused level codes fall back to level 0
  for (genvar i = 0; i < 2**LEVEL_W; i++) begin : g_lut
    if (i < N_LEVELS) begin : g_in
      assign lut[i] = START_TABLE[i*CNT_W +: CNT_W];
    end else begin : g_out
      assign lut[i] = START_TABLE[CNT_W-1:0];
    end
  end

  for (genvar i = 0; i < N_LEVELS; i++) begin : g_chk
    if (int'(START_TABLE[i*CNT_W +: CNT_W]) == 0 || int'(START_TABLE[i*CNT_W +: CNT_W]) > MAX_MS) begin : g_bad
      $error("countdown_timer_ml: START_TABLE entry %0d is zero or exceeds MAX_MS", i);
    end
  end

  assign start_val = lut[level];
  assign active    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign sync_clr  = start | clear;
  assign en        = active & ~pause & ~sync_clr;
  assign bonus_hit = active & bonus_valid;
  assign sum       = SW'(cnt_q) + (bonus_hit ? SW'(bonus_ms) : '0) - SW'(tick);
  assign sat_cnt   = (sum > MAX_SW) ? CNT_W'(MAX_SW) : sum[CNT_W-1:0];

  ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .tick     (tick)
  );

  // Next state and count: clear beats start beats bonus/tick; expiry only on a tick landing on 0
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = start_val;
    end else if (start) begin
      state_d = ST_RUN;
      cnt_d   = start_val;
    end else if (state_q == ST_IDLE) begin
      cnt_d = start_val;
    end else if (state_q == ST_EXPIRED) begin
      cnt_d = '0;
    end else begin
      cnt_d     = (tick | bonus_hit) ? sat_cnt : cnt_q;
      expired_d = tick & (sat_cnt == '0);
      state_d   = expired_d ? ST_EXPIRED : (pause ? ST_PAUSED : ST_RUN);
    end
  end

  // State, count and expiry pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end

  assign timer_value = cnt_q;
  assign running     = (state_q == ST_RUN);
  assign expired     = expired_q;
  assign time_up     = (state_q == ST_EXPIRED);

endmodule
